// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES cipher scheduler and its arbiter.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int AES_BLK_W    = 128;
    localparam int AES_CORE_LAT = 12;

    // Timer must be able to hold TIMEOUT_CYC-1 without wrapping.
    function automatic int timer_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester found
// when searching from ptr upward, wrapping modulo N.
module aes_rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_cipher_sched.sv
// Shares one AES-128 encrypt core between NUM_REQ requesters: round-robin grant,
// one block in flight, registered response with watchdog timeout.
module aes_cipher_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_text,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [AES_BLK_W-1:0]         rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         core_ld,
    output logic [AES_BLK_W-1:0]         core_key,
    output logic [AES_BLK_W-1:0]         core_text_in,
    input  logic                         core_done,
    input  logic [AES_BLK_W-1:0]         core_text_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = timer_width(TIMEOUT_CYC);

    state_e                 state_q,  state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]       timer_q,  timer_d;
    logic [ID_W-1:0]        id_q,     id_d;
    logic [AES_BLK_W-1:0]   data_q,   data_d;
    logic                   err_q,    err_d;
    logic                   valid_q,  valid_d;
    logic                   ld_q,     ld_d;
    logic                   busy_q,   busy_d;
    logic [AES_BLK_W-1:0]   key_q,    key_d;
    logic [AES_BLK_W-1:0]   text_q,   text_d;

    logic [NUM_REQ-1:0]     gnt;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       rr_next;

    aes_rr_arb #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are only offered while idle; reset masks them so nothing is accepted.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign rr_next   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : PTR_W'(id_q + 1'b1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        id_d     = id_q;
        data_d   = data_q;
        err_d    = err_q;
        valid_d  = valid_q;
        ld_d     = 1'b0;
        busy_d   = busy_q;
        key_d    = key_q;
        text_d   = text_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    key_d   = req_key[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                    text_d  = req_text[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                    id_d    = ID_W'(gnt_idx);
                    ld_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done arriving on the final timer cycle still counts as success.
                if (core_done) begin
                    data_d  = core_text_out;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = rr_next;
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            id_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ld_q     <= 1'b0;
            busy_q   <= 1'b0;
            key_q    <= '0;
            text_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            id_q     <= id_d;
            data_q   <= data_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ld_q     <= ld_d;
            busy_q   <= busy_d;
            key_q    <= key_d;
            text_q   <= text_d;
        end
    end

    assign rsp_valid    = valid_q;
    assign rsp_id       = id_q;
    assign rsp_data     = data_q;
    assign rsp_err      = err_q;
    assign busy         = busy_q;
    assign core_ld      = ld_q;
    assign core_key     = key_q;
    assign core_text_in = text_q;

endmodule
